imem_arbiter: RTL and testbench
===============================

# imem_arbiter

Single-cycle arbiter that shares the 128-byte instruction memory between the core's 32-bit fetch port and a byte-wide program-loader write port. It sits between the fetch stage / loader and the instruction memory array, issues at most one access per cycle, and returns registered fetch data one cycle after grant. Loader traffic has priority, bounded by a burst limit so fetch is never starved.

## Interface
- ADDR_W, 7: byte-address width (memory depth 2^ADDR_W bytes)
- MAX_LOAD_BURST, 8: consecutive loader grants allowed while fetch is pending (≥1)

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- f_req  in  1  fetch request
- f_addr  in  ADDR_W  fetch byte address (word-aligned expected)
- f_gnt  out  1  fetch accepted this cycle (combinational)
- f_rvalid  out  1  f_rdata/f_err valid (registered)
- f_rdata  out  32  fetched word, little-endian
- f_err  out  1  misaligned fetch flag, qualified by f_rvalid
- l_req  in  1  loader byte-write request
- l_addr  in  ADDR_W  loader byte address
- l_wdata  in  8  loader write byte
- l_gnt  out  1  loader write accepted this cycle (combinational)
- m_addr  out  ADDR_W  memory byte address
- m_we  out  1  memory byte write enable (written at clk edge)
- m_wdata  out  8  memory write byte
- m_rdata  in  32  memory combinational read {b[a+3],b[a+2],b[a+1],b[a]}

## Operation
- FSM states: LOAD_PRI (reset state), FETCH_PRI.
- LOAD_PRI: l_req → l_gnt; else f_req → f_gnt.
- FETCH_PRI: f_req → f_gnt; else l_req → l_gnt.
- At most one of f_gnt/l_gnt high; neither when no request.
- Burst counter burst_cnt (width clog2(MAX_LOAD_BURST)+1): in LOAD_PRI, increments on each l_gnt while f_req high; clears on f_gnt or when f_req low.
- LOAD_PRI → FETCH_PRI when l_gnt and f_req and burst_cnt == MAX_LOAD_BURST-1; burst_cnt clears.
- FETCH_PRI → LOAD_PRI on f_gnt, or when f_req low.
- Mux: l_gnt → m_addr=l_addr, m_we=1, m_wdata=l_wdata; otherwise m_addr=f_addr, m_we=0, m_wdata=0.
- On f_gnt: capture m_rdata into f_rdata, f_err = |f_addr[1:0]; f_rvalid=1 next cycle. f_rdata holds otherwise.
- Misaligned fetch still returns the unaligned word read; f_err only flags it.
- Address wrap (a+3 > 2^ADDR_W-1) is the memory's modulo behaviour; arbiter passes address unchanged.
- Requesters hold req/addr/data until granted; dropping req before grant is legal (no side effect).

## Timing
- Reset: f_rvalid=0, f_rdata=0, f_err=0, state=LOAD_PRI, burst_cnt=0. f_gnt/l_gnt/m_* follow inputs combinationally (m_we=0 unless l_req).
- Fetch latency: f_gnt in cycle N → f_rvalid, f_rdata in cycle N+1. Back-to-back fetch grants give one word per cycle.
- Write visible to a fetch granted in the next cycle (read-after-write latency 1).
- Simultaneous f_req and l_req: resolved by state as above; same-cycle same-address conflict impossible (one access per cycle).
- Reset mid-operation: pending f_rvalid dropped, state to LOAD_PRI; no partial write (m_we combinational, write occurs only at clock edge with rst_n high).

## Structure
- Shared package imem_pkg: ADDR_W default, state enum {LOAD_PRI, FETCH_PRI}, little-endian word assembly constant widths.
- No sub-module; FSM, counter and output register in one module. Memory array stays external.

## Test plan
- Fetch only: f_req=1, f_addr=0x04, mem word 0x00A00093 → f_gnt same cycle, f_rvalid=1 with f_rdata=0x00A00093, f_err=0 next cycle.
- Load then fetch: write bytes 0x13,0x00,0x00,0x00 to 0x08..0x0B, fetch 0x08 in next cycle → f_rdata=0x00000013.
- Starvation bound: l_req held continuously, f_req held, MAX_LOAD_BURST=8 → exactly 8 l_gnt, then 1 f_gnt, then loader again; repeats.
- Contention without pending fetch: l_req only for 20 cycles → 20 l_gnt, state stays LOAD_PRI, burst_cnt=0.
- Misaligned: f_addr=0x7E → f_rvalid with f_err=1, f_rdata={b[0x01],b[0x00],b[0x7F],b[0x7E]}.
- Reset mid-fetch: assert rst_n=0 between f_gnt and next edge → f_rvalid=0, f_rdata=0, state LOAD_PRI after release.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared constants and types for the instruction-memory arbiter slice.
package imem_pkg;

    // Default byte-address width: 2^7 = 128-byte instruction memory.
    localparam int unsigned IMEM_ADDR_W = 7;

    // Little-endian word assembly: four bytes per fetched word.
    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned WORD_BYTES  = 4;
    localparam int unsigned WORD_W      = BYTE_W * WORD_BYTES;

    // Arbiter priority state.
    typedef enum logic [0:0] {
        LOAD_PRI  = 1'b0,
        FETCH_PRI = 1'b1
    } arb_state_e;

endpackage

// File: rtl/imem_arbiter_if.sv
// Fetch port, loader port and memory-side bus of the instruction-memory arbiter.
interface imem_arbiter_if
    import imem_pkg::*;
#(
    parameter int unsigned ADDR_W = IMEM_ADDR_W
);

    // Fetch port
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_gnt;
    logic              f_rvalid;
    logic [WORD_W-1:0] f_rdata;
    logic              f_err;

    // Loader port
    logic              l_req;
    logic [ADDR_W-1:0] l_addr;
    logic [BYTE_W-1:0] l_wdata;
    logic              l_gnt;

    // Memory side
    logic [ADDR_W-1:0] m_addr;
    logic              m_we;
    logic [BYTE_W-1:0] m_wdata;
    logic [WORD_W-1:0] m_rdata;

    // Arbiter view
    modport slave (
        input  f_req, f_addr, l_req, l_addr, l_wdata, m_rdata,
        output f_gnt, f_rvalid, f_rdata, f_err, l_gnt, m_addr, m_we, m_wdata
    );

    // Requester / memory view
    modport master (
        output f_req, f_addr, l_req, l_addr, l_wdata, m_rdata,
        input  f_gnt, f_rvalid, f_rdata, f_err, l_gnt, m_addr, m_we, m_wdata
    );

endinterface

// File: rtl/imem_arbiter.sv
// Single-cycle arbiter sharing the instruction memory between the 32-bit
// fetch port and the byte-wide program loader. Loader has priority, bounded
// by MAX_LOAD_BURST consecutive grants while a fetch is pending.
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int unsigned ADDR_W         = IMEM_ADDR_W,
    parameter int unsigned MAX_LOAD_BURST = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    imem_arbiter_if.slave        bus
);

    localparam int unsigned      CNT_W      = $clog2(MAX_LOAD_BURST) + 1;
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_LOAD_BURST - 1);

    arb_state_e       state;
    logic [CNT_W-1:0] burst_cnt;
    logic             f_gnt_c;
    logic             l_gnt_c;

    // Grant selection: the current state decides which requester wins a tie.
    always_comb begin
        f_gnt_c = 1'b0;
        l_gnt_c = 1'b0;
        if (state == LOAD_PRI) begin
            l_gnt_c = bus.l_req;
            f_gnt_c = bus.f_req & ~bus.l_req;
        end else begin
            f_gnt_c = bus.f_req;
            l_gnt_c = bus.l_req & ~bus.f_req;
        end
    end

    assign bus.f_gnt = f_gnt_c;
    assign bus.l_gnt = l_gnt_c;

    // Memory mux: a granted loader write owns the address; otherwise fetch address.
    always_comb begin
        bus.m_addr  = bus.f_addr;
        bus.m_we    = 1'b0;
        bus.m_wdata = '0;
        if (l_gnt_c) begin
            bus.m_addr  = bus.l_addr;
            bus.m_we    = 1'b1;
            bus.m_wdata = bus.l_wdata;
        end
    end

    // Priority FSM and loader burst counter (counts only while fetch waits).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD_PRI;
            burst_cnt <= '0;
        end else begin
            case (state)
                LOAD_PRI: begin
                    if (l_gnt_c && bus.f_req) begin
                        if (burst_cnt == BURST_LAST) begin
                            state     <= FETCH_PRI;
                            burst_cnt <= '0;
                        end else begin
                            burst_cnt <= burst_cnt + 1'b1;
                        end
                    end else begin
                        burst_cnt <= '0;
                    end
                end
                FETCH_PRI: begin
                    burst_cnt <= '0;
                    if (f_gnt_c || !bus.f_req) begin
                        state <= LOAD_PRI;
                    end
                end
                default: begin
                    state     <= LOAD_PRI;
                    burst_cnt <= '0;
                end
            endcase
        end
    end

    // Fetch return register: data and alignment flag captured on grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.f_rvalid <= 1'b0;
            bus.f_rdata  <= '0;
            bus.f_err    <= 1'b0;
        end else begin
            bus.f_rvalid <= f_gnt_c;
            if (f_gnt_c) begin
                bus.f_rdata <= bus.m_rdata;
                bus.f_err   <= |bus.f_addr[1:0];
            end
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed self-checking bench for imem_arbiter with a fetch-return scoreboard.
module tb_imem_arbiter;
    import imem_pkg::*;

    localparam int unsigned AW    = 7;
    localparam int unsigned BURST = 8;

    typedef struct packed {
        logic [31:0] word;
        logic        err;
    } exp_t;

    logic       clk;
    logic       rst_n;
    int         checks;
    int         errors;
    logic [7:0] mem     [128];
    logic [7:0] ref_mem [128];
    exp_t       exp_q[$];

    imem_arbiter_if #(.ADDR_W(AW)) bus_if ();

    imem_arbiter #(
        .ADDR_W         (AW),
        .MAX_LOAD_BURST (BURST)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory environment: combinational little-endian read, byte write at edge.
    assign bus_if.m_rdata = {mem[7'(bus_if.m_addr + 7'd3)], mem[7'(bus_if.m_addr + 7'd2)],
                             mem[7'(bus_if.m_addr + 7'd1)], mem[bus_if.m_addr]};

    always @(posedge clk) begin
        if (rst_n && bus_if.m_we) mem[bus_if.m_addr] <= bus_if.m_wdata;
    end

    function automatic logic [31:0] model_word(input logic [6:0] a);
        return {ref_mem[7'(a + 7'd3)], ref_mem[7'(a + 7'd2)], ref_mem[7'(a + 7'd1)], ref_mem[a]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge, score the fetch return, check grants/mux.
    task automatic cycle(input string tag, input logic ef, input logic el);
        exp_t e;
        @(negedge clk);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_rvalid"}, 32'(bus_if.f_rvalid), 32'd1);
            chk({tag, "_rdata"},  bus_if.f_rdata,       e.word);
            chk({tag, "_err"},    32'(bus_if.f_err),    32'(e.err));
        end else begin
            chk({tag, "_rvalid0"}, 32'(bus_if.f_rvalid), 32'd0);
        end
        chk({tag, "_fgnt"}, 32'(bus_if.f_gnt), 32'(ef));
        chk({tag, "_lgnt"}, 32'(bus_if.l_gnt), 32'(el));
        if (el) begin
            chk({tag, "_mwe"},   32'(bus_if.m_we),    32'd1);
            chk({tag, "_maddr"}, 32'(bus_if.m_addr),  32'(bus_if.l_addr));
            chk({tag, "_mwd"},   32'(bus_if.m_wdata), 32'(bus_if.l_wdata));
            ref_mem[bus_if.l_addr] = bus_if.l_wdata;
        end else begin
            chk({tag, "_mwe"},   32'(bus_if.m_we),   32'd0);
            chk({tag, "_maddr"}, 32'(bus_if.m_addr), 32'(bus_if.f_addr));
        end
        if (ef) exp_q.push_back('{word: model_word(bus_if.f_addr), err: |bus_if.f_addr[1:0]});
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [6:0] a, input logic [7:0] d);
        bus_if.l_req = 1'b1; bus_if.l_addr = a; bus_if.l_wdata = d;
        cycle("load", 1'b0, 1'b1);
        bus_if.l_req = 1'b0;
    endtask

    task automatic fetch(input logic [6:0] a, input string tag);
        bus_if.f_req = 1'b1; bus_if.f_addr = a;
        cycle(tag, 1'b1, 1'b0);
        bus_if.f_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 128; i++) begin
            mem[i]     = 8'(i * 37 + 11);
            ref_mem[i] = 8'(i * 37 + 11);
        end
        mem[4] = 8'h93; mem[5] = 8'h00; mem[6] = 8'hA0; mem[7] = 8'h00;
        ref_mem[4] = 8'h93; ref_mem[5] = 8'h00; ref_mem[6] = 8'hA0; ref_mem[7] = 8'h00;

        rst_n = 1'b0;
        bus_if.f_req = 1'b0; bus_if.f_addr = '0;
        bus_if.l_req = 1'b0; bus_if.l_addr = '0; bus_if.l_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state; grants stay combinational during reset.
        chk("rst_rvalid", 32'(bus_if.f_rvalid), 32'd0);
        chk("rst_rdata",  bus_if.f_rdata,       32'd0);
        chk("rst_err",    32'(bus_if.f_err),    32'd0);
        chk("rst_state",  32'(dut.state),       32'(LOAD_PRI));
        chk("rst_cnt",    32'(dut.burst_cnt),   32'd0);
        chk("rst_mwe",    32'(bus_if.m_we),     32'd0);
        bus_if.f_req = 1'b1; bus_if.f_addr = 7'h20;
        #1;
        chk("rst_fgnt_comb", 32'(bus_if.f_gnt), 32'd1);
        @(posedge clk); #1;
        chk("rst_rvalid_hold", 32'(bus_if.f_rvalid), 32'd0);
        bus_if.f_req = 1'b0;
        rst_n = 1'b1;

        cycle("idle", 1'b0, 1'b0);

        // Fetch only: word 0x00A00093 at 0x04.
        fetch(7'h04, "fetch04");
        cycle("fetch04_ret", 1'b0, 1'b0);
        chk("fetch04_const", bus_if.f_rdata, 32'h00A00093);

        // Load 0x13,00,00,00 to 0x08..0x0B then fetch 0x08 next cycle.
        load(7'h08, 8'h13); load(7'h09, 8'h00); load(7'h0A, 8'h00); load(7'h0B, 8'h00);
        fetch(7'h08, "raw08");
        cycle("raw08_ret", 1'b0, 1'b0);
        chk("raw08_const", bus_if.f_rdata, 32'h00000013);

        // Back-to-back fetches: one word per cycle.
        bus_if.f_req = 1'b1;
        bus_if.f_addr = 7'h00; cycle("b2b0", 1'b1, 1'b0);
        bus_if.f_addr = 7'h10; cycle("b2b1", 1'b1, 1'b0);
        bus_if.f_addr = 7'h20; cycle("b2b2", 1'b1, 1'b0);
        bus_if.f_req = 1'b0;
        cycle("b2b_ret", 1'b0, 1'b0);

        // Starvation bound: 8 loader grants, then one fetch grant, repeating.
        bus_if.f_req = 1'b1; bus_if.f_addr = 7'h40;
        bus_if.l_req = 1'b1; bus_if.l_addr = 7'h40; bus_if.l_wdata = 8'h55;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < int'(BURST); k++) begin
                bus_if.l_wdata = 8'(r * 16 + k);
                cycle("starve_l", 1'b0, 1'b1);
            end
            cycle("starve_f", 1'b1, 1'b0);
        end
        cycle("starve_l_again", 1'b0, 1'b1);
        bus_if.f_req = 1'b0;

        // Loader only for 20 cycles: no priority flip, counter stays clear.
        for (int i = 0; i < 20; i++) begin
            bus_if.l_addr = 7'(8'h60 + i); bus_if.l_wdata = 8'(i) ^ 8'hA5;
            cycle("lonly", 1'b0, 1'b1);
        end
        bus_if.l_req = 1'b0;
        chk("lonly_state", 32'(dut.state),     32'(LOAD_PRI));
        chk("lonly_cnt",   32'(dut.burst_cnt), 32'd0);

        // Misaligned fetch at 0x7E wraps through address 0x00/0x01.
        load(7'h7E, 8'hAA); load(7'h7F, 8'hBB); load(7'h00, 8'hCC); load(7'h01, 8'hDD);
        fetch(7'h7E, "misal");
        cycle("misal_ret", 1'b0, 1'b0);
        chk("misal_const", bus_if.f_rdata, 32'hDDCCBBAA);
        chk("misal_errc",  32'(bus_if.f_err), 32'd1);

        // Reset between fetch grant and the next edge.
        cycle("pre_rst", 1'b0, 1'b0);
        bus_if.f_req = 1'b1; bus_if.f_addr = 7'h10;
        @(negedge clk);
        chk("midrst_fgnt", 32'(bus_if.f_gnt), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_rvalid", 32'(bus_if.f_rvalid), 32'd0);
        chk("midrst_rdata",  bus_if.f_rdata,       32'd0);
        chk("midrst_err",    32'(bus_if.f_err),    32'd0);
        chk("midrst_state",  32'(dut.state),       32'(LOAD_PRI));
        bus_if.f_req = 1'b0;
        @(posedge clk); #1;
        chk("midrst_rvalid2", 32'(bus_if.f_rvalid), 32'd0);
        rst_n = 1'b1;

        // Fetch after reset release still works.
        fetch(7'h0C, "post_rst");
        cycle("post_rst_ret", 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
